// File: rtl/in_arb_rr_mux.sv
// Round-robin input arbiter: pulls whole packets from NUM_QUEUES FWFT queues onto one
// registered output stream. A granted queue owns the output until its end-of-packet word.
module in_arb_rr_mux #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int NUM_QUEUES      = 4,
  parameter int QUEUE_SEL_WIDTH = $clog2(NUM_QUEUES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_QUEUES-1:0]            in_empty,
  output logic [NUM_QUEUES-1:0]            in_rd_en,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic                             state,
  output logic                             eop,
  output logic [QUEUE_SEL_WIDTH-1:0]       grant
);

  typedef enum logic {SELECT = 1'b0, PROCESS = 1'b1} state_t;

  localparam logic [NUM_QUEUES-1:0] RD_ONE = {{(NUM_QUEUES-1){1'b0}}, 1'b1};

  state_t                     state_r;
  logic [QUEUE_SEL_WIDTH-1:0] grant_r;
  logic [QUEUE_SEL_WIDTH-1:0] rr_ptr_r;
  logic                       in_data_phase_r;
  logic [DATA_WIDTH-1:0]      out_data_r;
  logic [CTRL_WIDTH-1:0]      out_ctrl_r;
  logic                       out_wr_r;
  logic                       eop_r;

  logic [QUEUE_SEL_WIDTH-1:0] sel_idx_s;
  logic                       sel_found_s;
  logic                       pop_s;
  logic                       eop_s;
  logic [DATA_WIDTH-1:0]      head_data_s;
  logic [CTRL_WIDTH-1:0]      head_ctrl_s;

  assign head_data_s = in_data[grant_r*DATA_WIDTH +: DATA_WIDTH];
  assign head_ctrl_s = in_ctrl[grant_r*CTRL_WIDTH +: CTRL_WIDTH];

  // Pick the first non-empty queue at or after rr_ptr, ascending with wrap.
  always_comb begin
    logic [QUEUE_SEL_WIDTH-1:0] idx_v;
    idx_v       = rr_ptr_r;
    sel_found_s = 1'b0;
    sel_idx_s   = rr_ptr_r;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      idx_v = rr_ptr_r + QUEUE_SEL_WIDTH'(i);
      if (!sel_found_s && !in_empty[idx_v]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = idx_v;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Pop strobe for the granted queue; a non-zero ctrl in the data phase ends the packet.
  always_comb begin
    pop_s    = 1'b0;
    in_rd_en = {NUM_QUEUES{1'b0}};
    if (!reset && (state_r == PROCESS) && !in_empty[grant_r] && out_rdy) begin
      pop_s    = 1'b1;
      in_rd_en = RD_ONE << grant_r;
    end else begin
      pop_s    = 1'b0;
    end
    eop_s = pop_s && in_data_phase_r && (head_ctrl_s != {CTRL_WIDTH{1'b0}});
  end

  // Output register stage plus SELECT/PROCESS control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= SELECT;
      grant_r         <= {QUEUE_SEL_WIDTH{1'b0}};
      rr_ptr_r        <= {QUEUE_SEL_WIDTH{1'b0}};
      in_data_phase_r <= 1'b0;
      out_data_r      <= {DATA_WIDTH{1'b0}};
      out_ctrl_r      <= {CTRL_WIDTH{1'b0}};
      out_wr_r        <= 1'b0;
      eop_r           <= 1'b0;
    end else begin
      out_wr_r <= pop_s;
      eop_r    <= eop_s;
      if (pop_s) begin
        out_data_r <= head_data_s;
        out_ctrl_r <= head_ctrl_s;
      end
      case (state_r)
        SELECT: begin
          if (sel_found_s) begin
            grant_r         <= sel_idx_s;
            state_r         <= PROCESS;
            in_data_phase_r <= 1'b0;
          end
        end
        PROCESS: begin
          if (eop_s) begin
            state_r         <= SELECT;
            rr_ptr_r        <= grant_r + 1'b1;
            in_data_phase_r <= 1'b0;
          end else if (pop_s && (head_ctrl_s == {CTRL_WIDTH{1'b0}})) begin
            in_data_phase_r <= 1'b1;
          end
        end
        default: state_r <= SELECT;
      endcase
    end
  end

  assign out_data = out_data_r;
  assign out_ctrl = out_ctrl_r;
  assign out_wr   = out_wr_r;
  assign eop      = eop_r;
  assign state    = state_r;
  assign grant    = grant_r;

endmodule

// File: tb/tb_in_arb_rr_mux.sv
// Bench for in_arb_rr_mux: table of packet groups with hand-computed output order and
// timing, plus hand-written backpressure, empty-stall and async-reset sequences.
module tb_in_arb_rr_mux;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NQ = 4;
  localparam int SW = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NQ*DW-1:0] in_data;
  logic [NQ*CW-1:0] in_ctrl;
  logic [NQ-1:0]    in_empty;
  logic [NQ-1:0]    in_rd_en;
  logic [DW-1:0]    out_data;
  logic [CW-1:0]    out_ctrl;
  logic             out_wr;
  logic             out_rdy;
  logic             state;
  logic             eop;
  logic [SW-1:0]    grant;

  in_arb_rr_mux #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ), .QUEUE_SEL_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
    .out_rdy(out_rdy), .state(state), .eop(eop), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          grp;
    int          q;
    logic [7:0]  ctrl;
    logic [63:0] data;
    logic        eop;
    int          gap;   // cycles since previous output word (first word: since load)
  } vec_t;

  typedef struct {
    logic [7:0]  ctrl;
    logic [63:0] data;
    logic        eop;
    int          cyc;
  } obs_t;

  vec_t        tbl[$];
  obs_t        obs[$];
  logic [71:0] fq[NQ][$];
  bit          hold[NQ];
  int          cyc;
  int          n_cmp;
  int          n_bad;
  logic [NQ-1:0] last_rd;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mk(int g, int q, int i);
    return {16'hC0DE, 16'h0000, 8'(g), 8'(q), 16'(i)};
  endfunction

  function automatic void add(int g, int q, logic [7:0] c, int i, logic e, int gap);
    tbl.push_back('{g, q, c, mk(g, q, i), e, gap});
  endfunction

  // Standard 3-word packet: header, one data word, last word.
  function automatic void add3(int g, int q, int gap0);
    add(g, q, 8'hFF, 0, 1'b0, gap0);
    add(g, q, 8'h00, 1, 1'b0, 1);
    add(g, q, 8'h10, 2, 1'b1, 1);
  endfunction

  task automatic drive();
    for (int i = 0; i < NQ; i++) begin
      if (fq[i].size() > 0 && !hold[i]) begin
        in_empty[i]          = 1'b0;
        in_data[i*DW +: DW]  = fq[i][0][63:0];
        in_ctrl[i*CW +: CW]  = fq[i][0][71:64];
      end else begin
        in_empty[i]          = 1'b1;
        in_data[i*DW +: DW]  = 64'd0;
        in_ctrl[i*CW +: CW]  = 8'd0;
      end
    end
  endtask

  // Sample on the falling edge, then pop whatever the DUT read at the rising edge.
  task automatic cycle();
    @(negedge clk);
    last_rd = in_rd_en;
    if (last_rd != 4'b0000) chk("rd_en_onehot", 64'($countones(last_rd)), 64'd1);
    if (eop) chk("eop_with_wr", 64'(out_wr), 64'd1);
    if (out_wr) obs.push_back('{out_ctrl, out_data, eop, cyc});
    @(posedge clk);
    #1;
    for (int i = 0; i < NQ; i++) begin
      if (last_rd[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    end
    drive();
    cyc++;
  endtask

  task automatic load(int g);
    foreach (tbl[k]) begin
      if (tbl[k].grp == g) fq[tbl[k].q].push_back({tbl[k].ctrl, tbl[k].data});
    end
    drive();
  endtask

  task automatic check_group(int g, int c0);
    vec_t e[$];
    int   budget;
    int   prev;
    budget = 0;
    foreach (tbl[k]) begin
      if (tbl[k].grp == g) e.push_back(tbl[k]);
    end
    while (obs.size() < e.size() && budget < 200) begin
      cycle();
      budget++;
    end
    repeat (3) cycle();
    chk($sformatf("g%0d_words", g), 64'(obs.size()), 64'(e.size()));
    for (int k = 0; k < e.size() && k < obs.size(); k++) begin
      prev = (k == 0) ? c0 : obs[k-1].cyc;
      chk($sformatf("g%0d_w%0d_data", g, k), obs[k].data, e[k].data);
      chk($sformatf("g%0d_w%0d_ctrl", g, k), 64'(obs[k].ctrl), 64'(e[k].ctrl));
      chk($sformatf("g%0d_w%0d_eop", g, k), 64'(obs[k].eop), 64'(e[k].eop));
      chk($sformatf("g%0d_w%0d_gap", g, k), 64'(obs[k].cyc - prev), 64'(e[k].gap));
    end
    chk($sformatf("g%0d_idle_state", g), 64'(state), 64'd0);
    chk($sformatf("g%0d_idle_wr", g), 64'(out_wr), 64'd0);
    chk($sformatf("g%0d_hold_data", g), out_data, e[e.size()-1].data);
  endtask

  task automatic run_group(int g);
    int c0;
    obs.delete();
    load(g);
    c0 = cyc;
    check_group(g, c0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    n_cmp = 0; n_bad = 0; cyc = 0;
    out_rdy = 1'b1; in_empty = 4'hF; in_data = '0; in_ctrl = 8'd0 ? '0 : '0;
    foreach (hold[i]) hold[i] = 1'b0;

    // Packet groups, listed in expected output order.
    add(0, 0, 8'hFF, 0, 1'b0, 2); add(0, 0, 8'hFF, 1, 1'b0, 1); add(0, 0, 8'h00, 2, 1'b0, 1);
    add(0, 0, 8'h00, 3, 1'b0, 1); add(0, 0, 8'h00, 4, 1'b0, 1); add(0, 0, 8'h10, 5, 1'b1, 1);
    add3(1, 1, 2); add3(1, 0, 2);
    add3(2, 0, 2); add3(2, 1, 2); add3(2, 2, 2); add3(2, 3, 2);
    add3(3, 0, 2); add3(3, 3, 2);
    add3(4, 1, 2);
    add3(5, 3, 2); add3(5, 0, 2);
    add(6, 1, 8'hFF, 0, 1'b0, 2); add(6, 1, 8'h00, 1, 1'b0, 1); add(6, 1, 8'h00, 2, 1'b0, 6);
    add(6, 1, 8'h00, 3, 1'b0, 1); add(6, 1, 8'h00, 4, 1'b0, 1); add(6, 1, 8'h10, 5, 1'b1, 1);
    add3(7, 0, 2); add3(7, 3, 2);
    add(8, 1, 8'hFF, 0, 1'b0, 2); add(8, 1, 8'h00, 1, 1'b0, 1); add(8, 1, 8'h00, 2, 1'b0, 1);
    add(8, 1, 8'h00, 3, 1'b0, 5); add(8, 1, 8'h10, 4, 1'b1, 1); add3(8, 2, 2);

    // Reset state
    #1 reset = 1'b1;
    #1;
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_eop", 64'(eop), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_rd_en", 64'(in_rd_en), 64'd0);
    repeat (2) cycle();
    reset = 1'b0;
    cycle();

    run_group(0);   // single q0 packet with two header words
    run_group(1);   // rr_ptr=1 after q0: q1 before q0
    reset = 1'b1;   // pulse between clock edges returns rr_ptr to 0
    #2;
    reset = 1'b0;
    run_group(2);   // all four queues in order
    chk("grant_after_g2", 64'(grant), 64'd3);
    run_group(3);   // wrapped rr_ptr=0: q0 before q3
    run_group(4);   // moves rr_ptr to 2
    run_group(5);   // rr_ptr=2: q3 before q0
    chk("grant_after_g5", 64'(grant), 64'd0);

    // Backpressure: out_rdy low for 5 cycles after two words
    obs.delete();
    load(6);
    c0 = cyc;
    repeat (3) cycle();
    out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_rd_en", 64'(last_rd), 64'd0);
    end
    chk("bp_words_after_drop", 64'(obs.size()), 64'd2);
    out_rdy = 1'b1;
    check_group(6, c0);

    // Async reset in the middle of a q2 packet
    obs.delete();
    fq[2].push_back({8'hFF, 64'hDEAD_0000_0000_0000});
    fq[2].push_back({8'h00, 64'hDEAD_0000_0000_0001});
    fq[2].push_back({8'h00, 64'hDEAD_0000_0000_0002});
    fq[2].push_back({8'h00, 64'hDEAD_0000_0000_0003});
    fq[2].push_back({8'h10, 64'hDEAD_0000_0000_0004});
    drive();
    repeat (3) cycle();
    chk("pre_rst_wr", 64'(out_wr), 64'd1);
    chk("pre_rst_state", 64'(state), 64'd1);
    chk("pre_rst_grant", 64'(grant), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_wr", 64'(out_wr), 64'd0);
    chk("midrst_eop", 64'(eop), 64'd0);
    chk("midrst_state", 64'(state), 64'd0);
    chk("midrst_grant", 64'(grant), 64'd0);
    chk("midrst_rd_en", 64'(in_rd_en), 64'd0);
    fq[2].delete();
    drive();
    obs.delete();
    repeat (2) cycle();
    chk("midrst_no_words", 64'(obs.size()), 64'd0);
    reset = 1'b0;
    run_group(7);   // restarts from rr_ptr=0: q0 before q3

    // Granted q1 runs dry for 4 cycles while q2 waits
    obs.delete();
    load(8);
    c0 = cyc;
    repeat (4) cycle();
    hold[1] = 1'b1;
    drive();
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("stall_rd_en", 64'(last_rd), 64'd0);
      chk("stall_state", 64'(state), 64'd1);
      chk("stall_grant", 64'(grant), 64'd1);
    end
    chk("stall_words", 64'(obs.size()), 64'd3);
    hold[1] = 1'b0;
    drive();
    check_group(8, c0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
